// File: rtl/cbus_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter_pkg
// Shared cache-bus (cbus) request/response types used by the cbus arbiter and
// its round-robin picker, plus a small helper that sizes requester indices.
//   cbus_req_t  : valid, write, addr, wdata   (requester -> memory side)
//   cbus_resp_t : ready, last, data           (memory side -> requester)
// -----------------------------------------------------------------------------
package cbus_rr_arbiter_pkg;

  localparam int CBUS_ADDR_W = 32;
  localparam int CBUS_DATA_W = 32;

  typedef struct packed {
    logic                   valid;
    logic                   write;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_DATA_W-1:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter_rr_pick
// Purely combinational round-robin picker: returns the first asserted bit of
// valid_vec scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_INPUTS.
// Ports:
//   valid_vec [NUM_INPUTS] in   request valid per requester
//   rr_ptr    [IDX_W]      in   most recently served requester
//   pick      [IDX_W]      out  chosen requester (0 when none)
//   any                    out  at least one requester is valid
// -----------------------------------------------------------------------------
module cbus_rr_arbiter_rr_pick
  import cbus_rr_arbiter_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  localparam int IDX_W      = idx_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] valid_vec,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic [IDX_W-1:0]      pick,
  output logic                  any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    cand = '0;
    // Offsets 1..NUM_INPUTS so rr_ptr itself is checked last.
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_INPUTS);
      if (!any && valid_vec[cand]) begin
        any  = 1'b1;
        pick = cand;
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_rr_arbiter
// Shares one cbus master port among NUM_INPUTS requesters with round-robin
// priority. The grant is decided combinationally in IDLE (no added latency)
// and then held on the owning requester until the response beat carrying
// oresp.last.
// Optional feature macro: CBUS_ARB_TIMEOUT_EN -- adds a watchdog that aborts a
// transaction after TIMEOUT_CYCLES stalled cycles and hands the requester a
// synthetic last beat so it unblocks.
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-low reset
//   ireqs        in   per-requester requests   [NUM_INPUTS]
//   iresps       out  per-requester responses  [NUM_INPUTS]
//   oreq         out  forwarded request
//   oresp        in   downstream response
//   grant_valid  out  a requester owns the bus this cycle
//   grant_idx    out  owning requester (0 when grant_valid=0)
//   timeout_err  out  one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter  int NUM_INPUTS     = 4,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int IDX_W          = idx_width(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_INPUTS],
  output cbus_resp_t       iresps [NUM_INPUTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout_err
);

  if (NUM_INPUTS < 1 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("cbus_rr_arbiter: NUM_INPUTS must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [NUM_INPUTS-1:0] valid_vec;
  logic [IDX_W-1:0]      pick;
  logic                  pick_any;

`ifdef CBUS_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      valid_vec[i] = ireqs[i].valid;
    end
  end

  cbus_rr_arbiter_rr_pick #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_rr_pick (
    .valid_vec (valid_vec),
    .rr_ptr    (rr_ptr_q),
    .pick      (pick),
    .any       (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    oreq        = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    grant_valid = 1'b0;
    grant_idx   = '0;
    timeout_err = 1'b0;
`ifdef CBUS_ARB_TIMEOUT_EN
    wd_d        = wd_q;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          oreq         = ireqs[pick];
          iresps[pick] = oresp;
          grant_valid  = 1'b1;
          grant_idx    = pick;
`ifdef CBUS_ARB_TIMEOUT_EN
          wd_d         = '0;
`endif
          // A single-beat transaction that completes in the grant cycle
          // never enters BUSY.
          if (oresp.ready && oresp.last) begin
            rr_ptr_d = pick;
          end else begin
            state_d    = ARB_BUSY;
            lock_idx_d = pick;
          end
        end
      end

      ARB_BUSY: begin
        // Owner stays locked even if its valid drops; no preemption.
        oreq               = ireqs[lock_idx_q];
        iresps[lock_idx_q] = oresp;
        grant_valid        = 1'b1;
        grant_idx          = lock_idx_q;
        if (oresp.ready && oresp.last) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = lock_idx_q;
        end
`ifdef CBUS_ARB_TIMEOUT_EN
        if (oresp.ready) begin
          wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Synthetic terminating beat so the stalled requester unblocks.
          state_d                  = ARB_IDLE;
          rr_ptr_d                 = lock_idx_q;
          timeout_err              = 1'b1;
          iresps[lock_idx_q].ready = 1'b1;
          iresps[lock_idx_q].last  = 1'b1;
          iresps[lock_idx_q].data  = '0;
          wd_d                     = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= IDX_W'(NUM_INPUTS - 1);
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifdef CBUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cbus_rr_arbiter
// Self-checking bench for cbus_rr_arbiter: directed scenarios followed by
// randomized requesters/responder, all compared every cycle against a
// transaction-level reference model (owner, last-served, stall count).
// -----------------------------------------------------------------------------
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  localparam int N = 4;
`ifdef CBUS_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       timeout_err;

  cbus_rr_arbiter #(
    .NUM_INPUTS     (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ireqs       (ireqs),
    .iresps      (iresps),
    .oreq        (oreq),
    .oresp       (oresp),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the bus, who was served last, stall count.
  int m_owner;
  int m_last;
  int m_wd;
  int m_beats;
  int last_gidx;
  bit pend [N];
  int blen [N];
  cbus_req_t pay [N];

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_wd    = 0;
    m_beats = 0;
  endtask

  function automatic int model_pick();
    if (m_owner >= 0) return m_owner;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (ireqs[j].valid) return j;
    end
    return -1;
  endfunction

  function automatic cbus_req_t mk_req();
    cbus_req_t r;
    r.valid = 1'b1;
    r.write = 1'($urandom);
    r.addr  = $urandom;
    r.wdata = $urandom;
    return r;
  endfunction

  task automatic set_resp(input bit r, input bit l);
    oresp.ready = r;
    oresp.last  = l;
    oresp.data  = $urandom;
  endtask

  task automatic clear_drv();
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    oresp = '0;
  endtask

  // One clock: predict, compare at negedge, advance model at posedge.
  task automatic cycle_chk(output int done_idx);
    int         cur;
    bit         tmo;
    cbus_req_t  eo;
    cbus_resp_t er;
    cur = model_pick();
    tmo = 1'b0;
`ifdef CBUS_ARB_TIMEOUT_EN
    if (m_owner >= 0 && !oresp.ready && m_wd == TO - 1) tmo = 1'b1;
`endif
    eo = '0;
    if (cur >= 0) eo = ireqs[cur];
    @(negedge clk);
    check_eq("oreq", 128'(oreq), 128'(eo));
    check_eq("grant_valid", 128'(grant_valid), 128'(cur >= 0));
    check_eq("grant_idx", 128'(grant_idx), 128'((cur >= 0) ? cur : 0));
    check_eq("timeout_err", 128'(timeout_err), 128'(tmo));
    for (int i = 0; i < N; i++) begin
      er = '0;
      if (i == cur) begin
        er = oresp;
        if (tmo) begin
          er.ready = 1'b1;
          er.last  = 1'b1;
          er.data  = '0;
        end
      end
      check_eq($sformatf("iresps%0d", i), 128'(iresps[i]), 128'(er));
    end
    last_gidx = grant_valid ? int'(grant_idx) : -1;
    @(posedge clk);
    done_idx = -1;
    if (!reset) begin
      model_reset();
    end else if (cur >= 0) begin
      if ((oresp.ready && oresp.last) || tmo) begin
        done_idx = cur;
        m_owner  = -1;
        m_last   = cur;
        m_wd     = 0;
        m_beats  = 0;
      end else begin
        if (m_owner < 0 || oresp.ready) m_wd = 0;
        else m_wd++;
        m_owner = cur;
        if (oresp.ready) m_beats++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    int d;
    reset = 1'b0;
    clear_drv();
    cycle_chk(d);
    cycle_chk(d);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL sim_bound: got still running, required finished");
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    int d;
    clear_drv();
    model_reset();
    last_gidx = -1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle_chk(d);
    check_eq("rst_gv", 128'(last_gidx), 128'(-1));
    reset = 1'b1;

    // Requester 1 alone, 4-beat burst, ready every cycle.
    ireqs[1] = mk_req();
    for (int b = 1; b <= 4; b++) begin
      set_resp(1'b1, b == 4);
      cycle_chk(d);
      check_eq("t1_gidx", 128'(last_gidx), 128'(1));
    end
    clear_drv();
    cycle_chk(d);
    check_eq("t1_gv_fall", 128'(last_gidx), 128'(-1));
    ireqs[1] = mk_req();
    ireqs[2] = mk_req();
    set_resp(1'b1, 1'b1);
    cycle_chk(d);
    check_eq("t1_rrptr", 128'(last_gidx), 128'(2));

    // All four continuously valid, single-beat: order 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < N; i++) ireqs[i] = mk_req();
    for (int k = 0; k < 8; k++) begin
      set_resp(1'b1, 1'b1);
      cycle_chk(d);
      check_eq("t2_order", 128'(last_gidx), 128'(k % N));
    end

    // Req 2 busy while req 0 asserts; req 0 granted right after.
    clear_drv();
    ireqs[2] = mk_req();
    cycle_chk(d);
    ireqs[0] = mk_req();
    for (int k = 0; k < 3; k++) begin
      set_resp(1'b0, 1'b0);
      cycle_chk(d);
      check_eq("t3_lock", 128'(last_gidx), 128'(2));
    end
    set_resp(1'b1, 1'b1);
    cycle_chk(d);
    ireqs[2] = '0;
    oresp    = '0;
    cycle_chk(d);
    check_eq("t3_next", 128'(last_gidx), 128'(0));
    set_resp(1'b1, 1'b1);
    cycle_chk(d);

    // Reset in the middle of a req 1 burst.
    clear_drv();
    ireqs[1] = mk_req();
    for (int k = 0; k < 2; k++) begin
      set_resp(1'b1, 1'b0);
      cycle_chk(d);
    end
    reset = 1'b0;
    clear_drv();
    cycle_chk(d);
    cycle_chk(d);
    check_eq("t5_rst_gv", 128'(last_gidx), 128'(-1));
    reset    = 1'b1;
    ireqs[0] = mk_req();
    ireqs[1] = mk_req();
    set_resp(1'b1, 1'b1);
    cycle_chk(d);
    check_eq("t5_after", 128'(last_gidx), 128'(0));

`ifdef CBUS_ARB_TIMEOUT_EN
    // Stalled downstream: watchdog fires 8 cycles after the grant.
    do_reset();
    ireqs[2] = mk_req();
    ireqs[3] = mk_req();
    for (int c = 0; c <= 9; c++) begin
      set_resp(1'b0, 1'b0);
      cycle_chk(d);
      if (c == 8) begin
        check_eq("t6_tmo", 128'(timeout_err), 128'(1));
        check_eq("t6_last", 128'(iresps[2].last), 128'(1));
      end
      if (c == 9) check_eq("t6_next", 128'(last_gidx), 128'(3));
    end
`endif

    // Randomized requesters honouring the hold-until-last contract.
    do_reset();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int cur;
      bit r;
      if ($urandom_range(249) == 0) begin
        do_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        continue;
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          blen[i] = 1 + $urandom_range(3);
          pay[i]  = mk_req();
        end
        if (pend[i]) begin
          ireqs[i] = pay[i];
        end else begin
          ireqs[i]       = mk_req();
          ireqs[i].valid = 1'b0;
        end
      end
      cur = model_pick();
      if (cur >= 0) begin
        r = ($urandom_range(3) != 0);
        set_resp(r, r && (m_beats + 1 >= blen[cur]));
      end else begin
        set_resp(1'($urandom), 1'($urandom));
      end
      cycle_chk(d);
      if (d >= 0) pend[d] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
